// File: rtl/leds_pkg.sv
// Shared constants and types for the LED fade driver slice.
package leds_pkg;

    localparam int LED_WIDTH        = 14;
    localparam int PWM_BITS_DEFAULT = 8;

    typedef logic [PWM_BITS_DEFAULT-1:0] level_t;

    localparam level_t LEVEL_MAX = '1;

endpackage

// File: rtl/leds_fade_channel.sv
// One LED channel: brightness level ramping toward an on/off target, rendered
// against the shared PWM counter.
module leds_fade_channel
    import leds_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                instant,
    input  logic                target_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] target;

    assign target    = target_on ? MAX : '0;
    assign at_target = (level == target);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
            // Stepping only toward the target means the level can never wrap.
            if (instant)
                level <= target;
            else if (tick && (level < target))
                level <= level + 1'b1;
            else if (tick && (level > target))
                level <= level - 1'b1;

            led <= (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/leds_fade_driver.sv
// LED fade driver: turns the PIO pattern into per-LED linear fades rendered
// with a shared free-running PWM counter.
module leds_fade_driver
    import leds_pkg::*;
#(
    parameter int WIDTH    = LED_WIDTH,
    parameter int PWM_BITS = PWM_BITS_DEFAULT,
    parameter int STEP_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             instant,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] led_out,
    output logic             busy
);

    localparam int                  PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    // MAX-1: the counter period is MAX so a level of MAX stays high throughout.
    localparam logic [PWM_BITS-1:0] PWM_LAST = ~(PWM_BITS'(1));

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic [WIDTH-1:0]    at_target;

    assign tick = enable && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            if (!enable || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + 1'b1;

            if (pwm_cnt == PWM_LAST)
                pwm_cnt <= '0;
            else
                pwm_cnt <= pwm_cnt + 1'b1;

            busy <= ~&at_target;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        leds_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick      (tick),
            .instant   (instant),
            .target_on (pattern[i]),
            .pwm_cnt   (pwm_cnt),
            .led       (led_out[i]),
            .at_target (at_target[i])
        );
    end

endmodule

// File: tb/tb_leds_fade_driver.sv
// Randomized bench for leds_fade_driver against a behavioural brightness model.
module tb_leds_fade_driver;

    localparam int WIDTH    = 14;
    localparam int PWM_BITS = 4;
    localparam int STEP_DIV = 4;
    localparam int MAX      = 15;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             instant;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] led_out;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Model: brightness per LED, position in the PWM period, cycles into the
    // current fade step, and the outputs expected after the next edge.
    int               lvl [WIDTH];
    int               pwm_phase;
    int               step_phase;
    logic [WIDTH-1:0] exp_led;
    logic             exp_busy;

    leds_fade_driver #(
        .WIDTH    (WIDTH),
        .PWM_BITS (PWM_BITS),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .instant (instant),
        .pattern (pattern),
        .led_out (led_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) lvl[i] = 0;
        pwm_phase  = 0;
        step_phase = 0;
        exp_led    = '0;
        exp_busy   = 1'b0;
    endtask

    // Called at a falling edge: apply inputs, compare the outputs of the last
    // rising edge, advance the model by one clock, move to the next falling edge.
    task automatic cycle(input logic en, input logic inst, input logic [WIDTH-1:0] pat);
        bit tick;
        int tgt;
        logic any_off;
        enable  = en;
        instant = inst;
        pattern = pat;
        check("led_out", 32'(led_out), 32'(exp_led));
        check("busy", 32'(busy), 32'(exp_busy));

        tick    = en && (step_phase == STEP_DIV - 1);
        any_off = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            tgt        = pat[i] ? MAX : 0;
            exp_led[i] = (pwm_phase < lvl[i]);
            if (lvl[i] != tgt) any_off = 1'b1;
            if (inst)                    lvl[i] = tgt;
            else if (tick && lvl[i] < tgt) lvl[i] = lvl[i] + 1;
            else if (tick && lvl[i] > tgt) lvl[i] = lvl[i] - 1;
        end
        exp_busy   = any_off;
        pwm_phase  = (pwm_phase + 1) % MAX;
        step_phase = en ? (step_phase + 1) % STEP_DIV : 0;

        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted between edges must clear the outputs without a clock.
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_led_out", 32'(led_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        logic             en;

        reset_n = 1'b0;
        enable  = 1'b0;
        instant = 1'b0;
        pattern = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_led_out", 32'(led_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;

        // Fade up channel 0 from dark to full.
        repeat (70) cycle(1'b1, 1'b0, WIDTH'(14'h0001));
        check("fade_up_full", 32'(led_out[0]), 32'h1);

        // Reverse mid-ramp at level 7.
        cycle(1'b1, 1'b1, '0);
        for (int k = 0; k < 100 && lvl[0] != 7; k++) cycle(1'b1, 1'b0, WIDTH'(14'h0001));
        repeat (40) cycle(1'b1, 1'b0, '0);

        // Instant all-on, even with fading disabled.
        cycle(1'b0, 1'b1, WIDTH'(14'h3FFF));
        repeat (20) cycle(1'b1, 1'b0, WIDTH'(14'h3FFF));
        check("instant_all_on", 32'(led_out), 32'h3FFF);

        // Multi-channel: even channels fall, odd channels hold.
        repeat (70) cycle(1'b1, 1'b0, WIDTH'(14'h2AAA));
        check("multi_final", 32'(led_out), 32'h2AAA);

        // Freeze channel 3 at level 9, then resume.
        cycle(1'b1, 1'b1, '0);
        for (int k = 0; k < 100 && lvl[3] != 9; k++) cycle(1'b1, 1'b0, WIDTH'(14'h0008));
        repeat (20) cycle(1'b0, 1'b0, WIDTH'(14'h0008));
        repeat (40) cycle(1'b1, 1'b0, WIDTH'(14'h0008));

        // Randomized traffic.
        pat = WIDTH'($urandom);
        en  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39) == 0) pat = WIDTH'($urandom);
            if ($urandom_range(49) == 0) en = ~en;
            cycle(en, $urandom_range(199) == 0, pat);
        end

        // Asynchronous reset while all LEDs are lit.
        cycle(1'b1, 1'b1, WIDTH'(14'h3FFF));
        repeat (5) cycle(1'b1, 1'b0, WIDTH'(14'h3FFF));
        pattern = WIDTH'($urandom);
        async_reset();
        repeat (40) cycle(1'b1, 1'b0, WIDTH'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
